// File: rtl/phase_shift_pkg.sv
// phase_shift_pkg
//   Shared definitions for the DCM phase-shift controller: state encoding
//   and default widths of the fine-step field and the full phase word.
//   Optional feature macro used by the controller: PS_WATCHDOG_EN.
package phase_shift_pkg;

  localparam int FINE_W_DEF  = 6;
  localparam int PHASE_W_DEF = FINE_W_DEF + 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_QUAD = 3'd1,
    ST_STEP = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } ps_state_e;

endpackage

// File: rtl/phase_shift_watchdog.sv
// phase_shift_watchdog
//   Counts clocks spent waiting for psdone and flags expiry on the
//   TIMEOUT-th consecutive waiting clock.
// Ports:
//   clock_i    system clock, rising edge
//   reset_n_i  asynchronous active-low reset
//   clear_i    1 = not waiting; counter held at zero
//   expire_o   high during the TIMEOUT-th waiting clock
module phase_shift_watchdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic clock_i,
  input  logic reset_n_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = !clear_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/phase_shift_ctrl.sv
// phase_shift_ctrl
//   Steps a DCM fine phase shift and a clock quadrant mux to a requested
//   phase word {quadrant[1:0], fine[FINE_W-1:0]}.
//   Macro PS_WATCHDOG_EN: when defined, a psdone timeout aborts the move
//   and raises the sticky error flag; when undefined, error is always 0.
// Ports:
//   clock          40 MHz system clock, rising edge
//   reset_n        asynchronous active-low reset
//   fire           start request, sampled only while idle
//   phase_target   requested phase word
//   psdone         DCM phase-shift-done strobe
//   psen           DCM phase-shift enable, one clock per fine step
//   psincdec       step direction, 1 = increment
//   hcycle/qcycle  quadrant selects to the clock mux
//   phase_current  {hcycle, qcycle, fine count} actually applied
//   busy           high whenever not idle
//   done           one-clock completion pulse
//   error          sticky psdone-timeout flag
//
// state   | meaning
// IDLE    | waiting for fire
// QUAD    | load quadrant selects from latched target
// STEP    | compare fine count, issue psen or finish
// WAIT    | wait for psdone from the DCM
// DONE    | finish; done pulses on the following clock
module phase_shift_ctrl
  import phase_shift_pkg::*;
#(
  parameter int PS_TIMEOUT = 1023,
  parameter int FINE_W     = FINE_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              fire,
  input  logic [FINE_W+1:0] phase_target,
  input  logic              psdone,
  output logic              psen,
  output logic              psincdec,
  output logic              hcycle,
  output logic              qcycle,
  output logic [FINE_W+1:0] phase_current,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int PHASE_W = FINE_W + 2;
  localparam logic [FINE_W-1:0] FINE_MAX = '1;

  ps_state_e          state_q, state_d;
  logic [PHASE_W-1:0] target_q, target_d;
  logic [FINE_W-1:0]  fine_q, fine_d;
  logic               hcycle_q, hcycle_d;
  logic               qcycle_q, qcycle_d;
  logic               psen_q, psen_d;
  logic               psincdec_q, psincdec_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               wd_expire;
  logic [FINE_W-1:0]  target_fine;

  assign target_fine = target_q[FINE_W-1:0];

`ifdef PS_WATCHDOG_EN
  phase_shift_watchdog #(
    .TIMEOUT (PS_TIMEOUT)
  ) u_watchdog (
    .clock_i   (clock),
    .reset_n_i (reset_n),
    .clear_i   (state_q != ST_WAIT),
    .expire_o  (wd_expire)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (PS_TIMEOUT == 0);
  assign wd_expire      = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    fine_d     = fine_q;
    hcycle_d   = hcycle_q;
    qcycle_d   = qcycle_q;
    psen_d     = 1'b0;
    psincdec_d = psincdec_q;
    done_d     = 1'b0;
    error_d    = error_q;

    case (state_q)
      ST_IDLE: begin
        if (fire) begin
          target_d = phase_target;
          error_d  = 1'b0;
          state_d  = ST_QUAD;
        end
      end
      ST_QUAD: begin
        // Both selects load on the same edge so the mux never sees an
        // intermediate quadrant.
        hcycle_d = target_q[PHASE_W-1];
        qcycle_d = target_q[PHASE_W-2];
        state_d  = ST_STEP;
      end
      ST_STEP: begin
        if (fine_q == target_fine) begin
          state_d = ST_DONE;
        end else begin
          psen_d     = 1'b1;
          psincdec_d = (target_fine > fine_q);
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // psen is registered, so psen_q is high on the first WAIT clock;
        // a psdone seen then arrived with the enable and is not an answer.
        if (psdone && !psen_q) begin
          if (psincdec_q && (fine_q != FINE_MAX)) begin
            fine_d = fine_q + 1'b1;
          end else if (!psincdec_q && (fine_q != '0)) begin
            fine_d = fine_q - 1'b1;
          end
          state_d = ST_STEP;
        end else if (wd_expire) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      target_q   <= '0;
      fine_q     <= '0;
      hcycle_q   <= 1'b0;
      qcycle_q   <= 1'b0;
      psen_q     <= 1'b0;
      psincdec_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      fine_q     <= fine_d;
      hcycle_q   <= hcycle_d;
      qcycle_q   <= qcycle_d;
      psen_q     <= psen_d;
      psincdec_q <= psincdec_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign psen          = psen_q;
  assign psincdec      = psincdec_q;
  assign hcycle        = hcycle_q;
  assign qcycle        = qcycle_q;
  assign phase_current = {hcycle_q, qcycle_q, fine_q};
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign error         = error_q;

endmodule
